// File: rtl/mmppc_pkg.sv
// mmppc_pkg: shared mode/state encodings for the multi-mode ping-pong counter
package mmppc_pkg;
    localparam logic [1:0] MODE_PP      = 2'b00;
    localparam logic [1:0] MODE_WRAP    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    typedef enum logic [1:0] {ST_RUN, ST_DWELL, ST_DONE} state_e;
    function automatic logic [1:0] eff_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_PP : m;
    endfunction
endpackage

// File: rtl/mmppc_step_unit.sv
// mmppc_step_unit: one step from i_out toward i_dir, saturating at or wrapping past the bounds
// Ports: i_out/i_step/i_min/i_max operands, i_dir 1=up, i_wrap selects wrap instead of saturate;
//        o_next next value, o_hit_max/o_hit_min set when the step lands on (or wraps past) a bound
module mmppc_step_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_out,
    input  logic [WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0] i_min,
    input  logic [WIDTH-1:0] i_max,
    input  logic             i_dir,
    input  logic             i_wrap,
    output logic [WIDTH-1:0] o_next,
    output logic             o_hit_max,
    output logic             o_hit_min
);
    logic [WIDTH:0] w_step, w_up_gap, w_dn_gap;
    assign w_step   = (i_step == '0) ? (WIDTH+1)'(1) : {1'b0, i_step};
    // gaps are one bit wider so the comparison never wraps through 0 or 2^WIDTH
    assign w_up_gap = {1'b0, i_max} - {1'b0, i_out};
    assign w_dn_gap = {1'b0, i_out} - {1'b0, i_min};
    assign o_hit_max = i_dir & (i_wrap ? (w_up_gap < w_step) : (w_up_gap <= w_step));
    assign o_hit_min = ~i_dir & (i_wrap ? (w_dn_gap < w_step) : (w_dn_gap <= w_step));
    assign o_next = o_hit_max ? (i_wrap ? i_min : i_max) :
                    o_hit_min ? (i_wrap ? i_max : i_min) :
                    i_dir     ? i_out + w_step[WIDTH-1:0] : i_out - w_step[WIDTH-1:0];
endmodule

// File: rtl/multi_mode_ping_pong_counter.sv
// multi_mode_ping_pong_counter: ping-pong / wrap / one-shot counter with dwell, load and bounce count
// Ports: clk, rst (async, active high); enable, flip, mode, max, min, step, dwell, load, load_val in;
//        direction, out, at_max, at_min, done, bounce_cnt out
module multi_mode_ping_pong_counter
    import mmppc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 4,
    parameter int BCNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               flip,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   max,
    input  logic [WIDTH-1:0]   min,
    input  logic [WIDTH-1:0]   step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic               direction,
    output logic [WIDTH-1:0]   out,
    output logic               at_max,
    output logic               at_min,
    output logic               done,
    output logic [BCNT_W-1:0]  bounce_cnt
);
    state_e             r_state, w_state_n;
    logic [WIDTH-1:0]   r_out, w_out_n, w_next;
    logic               r_dir, w_dir_n, r_done, w_done_n;
    logic [BCNT_W-1:0]  r_bcnt, w_bcnt_n, w_bcnt_sat;
    logic [DWELL_W-1:0] r_dcnt, w_dcnt_n;
    logic [1:0]         w_mode;
    logic               w_at_end, w_inside, w_mv_dir, w_hit_max, w_hit_min;

    assign w_mode     = eff_mode(mode);
    assign w_at_end   = (r_out == max && r_dir) || (r_out == min && !r_dir);
    assign w_inside   = (r_out != max) && (r_out != min);
    assign w_bcnt_sat = (&r_bcnt) ? r_bcnt : r_bcnt + BCNT_W'(1);
    // direction the next move takes; ping-pong reverses at an endpoint, on leaving dwell, or on an inside flip
    assign w_mv_dir = (w_mode == MODE_ONESHOT) ? 1'b1 :
                      (w_mode == MODE_WRAP)    ? r_dir ^ flip :
                      r_dir ^ ((r_state == ST_DWELL) | w_at_end | (w_inside & flip));

    mmppc_step_unit #(.WIDTH(WIDTH)) u_step (
        .i_out     (r_out),
        .i_step    (step),
        .i_min     (min),
        .i_max     (max),
        .i_dir     (w_mv_dir),
        .i_wrap    (w_mode == MODE_WRAP),
        .o_next    (w_next),
        .o_hit_max (w_hit_max),
        .o_hit_min (w_hit_min)
    );

    always_comb begin
        w_state_n = r_state;
        w_out_n   = r_out;
        w_dir_n   = r_dir;
        w_done_n  = r_done;
        w_bcnt_n  = r_bcnt;
        w_dcnt_n  = r_dcnt;
        if (load) begin
            w_out_n   = load_val;
            w_dir_n   = 1'b1;
            w_done_n  = 1'b0;
            w_bcnt_n  = '0;
            w_dcnt_n  = '0;
            w_state_n = ST_RUN;
        end else if (enable && max > min && r_state != ST_DONE) begin
            if (r_out < min || r_out > max) begin
                w_out_n   = min;
                w_dir_n   = 1'b1;
                w_state_n = ST_RUN;
            end else if (w_mode != MODE_PP && r_state == ST_DWELL) begin
                w_state_n = ST_RUN;
            end else if (w_mode == MODE_ONESHOT) begin
                w_out_n = w_next;
                w_dir_n = 1'b1;
                // counting up only, so any hit means out lands on max
                if (w_hit_max | w_hit_min) begin
                    w_state_n = ST_DONE;
                    w_done_n  = 1'b1;
                end
            end else if (w_mode == MODE_WRAP) begin
                w_out_n = w_next;
                w_dir_n = w_mv_dir;
            end else if (r_state == ST_DWELL && r_dcnt > DWELL_W'(1)) begin
                w_dcnt_n = r_dcnt - DWELL_W'(1);
            end else if (r_state == ST_RUN && w_at_end && dwell != '0) begin
                w_state_n = ST_DWELL;
                w_dcnt_n  = dwell;
            end else begin
                w_out_n   = w_next;
                w_dir_n   = w_mv_dir;
                w_dcnt_n  = '0;
                w_state_n = ST_RUN;
                if (r_state == ST_DWELL || w_at_end) w_bcnt_n = w_bcnt_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_out   <= '0;
            r_dir   <= 1'b1;
            r_done  <= 1'b0;
            r_bcnt  <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_n;
            r_out   <= w_out_n;
            r_dir   <= w_dir_n;
            r_done  <= w_done_n;
            r_bcnt  <= w_bcnt_n;
            r_dcnt  <= w_dcnt_n;
        end
    end

    assign out        = r_out;
    assign direction  = r_dir;
    assign done       = r_done;
    assign bounce_cnt = r_bcnt;
    assign at_max     = (r_out == max);
    assign at_min     = (r_out == min);
endmodule

// File: tb/tb_multi_mode_ping_pong_counter.sv
// tb_multi_mode_ping_pong_counter: directed vectors with a queue scoreboard and negedge monitor
module tb_multi_mode_ping_pong_counter;
    logic       clk = 1'b0, rst = 1'b1;
    logic       en = 1'b0, flp = 1'b0, ld = 1'b0, e2 = 1'b0;
    logic [1:0] md = 2'b00;
    logic [7:0] mx = 8'd5, mn = 8'd2, stp = 8'd1, ldv = 8'd0;
    logic [3:0] dw = 4'd0;
    logic       dir1, am1, an1, dn1, dir2, am2, an2, dn2;
    logic [7:0] out1, out2;
    logic [15:0] b1;
    logic [1:0] b2;

    always #5 clk = ~clk;

    multi_mode_ping_pong_counter dut (
        .clk(clk), .rst(rst), .enable(en), .flip(flp), .mode(md), .max(mx), .min(mn),
        .step(stp), .dwell(dw), .load(ld), .load_val(ldv), .direction(dir1), .out(out1),
        .at_max(am1), .at_min(an1), .done(dn1), .bounce_cnt(b1)
    );

    multi_mode_ping_pong_counter #(.BCNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .enable(e2), .flip(1'b0), .mode(2'b00), .max(8'd1), .min(8'd0),
        .step(8'd1), .dwell(4'd0), .load(1'b0), .load_val(8'd0), .direction(dir2), .out(out2),
        .at_max(am2), .at_min(an2), .done(dn2), .bounce_cnt(b2)
    );

    typedef struct {
        int          cyc;
        bit          sel;
        string       nm;
        logic [7:0]  o;
        logic        d;
        logic        dn;
        logic [15:0] b;
        logic        am;
        logic        an;
    } exp_t;

    exp_t q[$];
    exp_t me;
    logic [27:0] act, expv;
    int cyc_cnt = 0, n_chk = 0, n_pass = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
            me   = q.pop_front();
            act  = me.sel ? {out2, dir2, dn2, 14'b0, b2, am2, an2} : {out1, dir1, dn1, b1, am1, an1};
            expv = {me.o, me.d, me.dn, me.b, me.am, me.an};
            n_chk++;
            if (act === expv) n_pass++;
            else $display("FAIL %s: got out=%0d dir=%b done=%b bcnt=%0d at_max=%b at_min=%b, want out=%0d dir=%b done=%b bcnt=%0d at_max=%b at_min=%b",
                          me.nm, act[27:20], act[19], act[18], act[17:2], act[1], act[0],
                          expv[27:20], expv[19], expv[18], expv[17:2], expv[1], expv[0]);
        end
    end

    task automatic push(input string nm, input int cyc, input bit sel, input logic [7:0] o,
                        input logic d, input logic dn, input logic [15:0] b);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.nm = nm; e.o = o; e.d = d; e.dn = dn; e.b = b;
        e.am = sel ? (o == 8'd1) : (o == mx);
        e.an = sel ? (o == 8'd0) : (o == mn);
        q.push_back(e);
    endtask

    task automatic tick(input string nm, input bit sel, input logic [7:0] o,
                        input logic d, input logic dn, input logic [15:0] b);
        push(nm, cyc_cnt + 1, sel, o, d, dn, b);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        tick("reset", 0, 0, 1, 0, 0);
        rst = 1'b0; en = 1'b1;
        tick("pp_resync", 0, 2, 1, 0, 0);
        tick("pp_3", 0, 3, 1, 0, 0);
        tick("pp_4", 0, 4, 1, 0, 0);
        tick("pp_5", 0, 5, 1, 0, 0);
        tick("pp_rev_max", 0, 4, 0, 0, 1);
        tick("pp_3d", 0, 3, 0, 0, 1);
        tick("pp_2d", 0, 2, 0, 0, 1);
        tick("pp_rev_min", 0, 3, 1, 0, 2);

        ld = 1'b1; ldv = 8'd0; mn = 8'd0; mx = 8'd3; dw = 4'd2;
        tick("dw_load", 0, 0, 1, 0, 0);
        ld = 1'b0;
        tick("dw_1", 0, 1, 1, 0, 0);
        tick("dw_2", 0, 2, 1, 0, 0);
        tick("dw_3", 0, 3, 1, 0, 0);
        tick("dw_hold1", 0, 3, 1, 0, 0);
        tick("dw_hold2", 0, 3, 1, 0, 0);
        tick("dw_leave", 0, 2, 0, 0, 1);
        tick("dw_1d", 0, 1, 0, 0, 1);
        tick("dw_0d", 0, 0, 0, 0, 1);
        tick("dw_min_enter", 0, 0, 0, 0, 1);
        en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        push("async_rst", cyc_cnt, 0, 0, 1, 0, 0);
        @(negedge clk);
        #1 rst = 1'b0;

        mn = 8'd0; mx = 8'd10; stp = 8'd4; dw = 4'd0; md = 2'b00; en = 1'b1;
        tick("sat_4", 0, 4, 1, 0, 0);
        tick("sat_8", 0, 8, 1, 0, 0);
        tick("sat_10", 0, 10, 1, 0, 0);
        tick("sat_6", 0, 6, 0, 0, 1);
        flp = 1'b1;
        tick("flip_inside", 0, 10, 1, 0, 1);
        flp = 1'b0;
        tick("after_flip", 0, 6, 0, 0, 2);

        ld = 1'b1; ldv = 8'd1; md = 2'b01; mn = 8'd1; mx = 8'd6; stp = 8'd4;
        tick("wr_load", 0, 1, 1, 0, 0);
        ld = 1'b0;
        tick("wr_5", 0, 5, 1, 0, 0);
        tick("wr_wrap_up", 0, 1, 1, 0, 0);
        tick("wr_5b", 0, 5, 1, 0, 0);
        flp = 1'b1;
        tick("wr_flip", 0, 1, 0, 0, 0);
        flp = 1'b0;
        tick("wr_wrap_dn", 0, 6, 0, 0, 0);

        ld = 1'b1; ldv = 8'd0; md = 2'b10; mn = 8'd0; mx = 8'd7; stp = 8'd3;
        tick("os_load", 0, 0, 1, 0, 0);
        ld = 1'b0;
        tick("os_3", 0, 3, 1, 0, 0);
        tick("os_6", 0, 6, 1, 0, 0);
        tick("os_done", 0, 7, 1, 1, 0);
        tick("os_hold1", 0, 7, 1, 1, 0);
        tick("os_hold2", 0, 7, 1, 1, 0);
        ld = 1'b1; ldv = 8'd2;
        tick("os_reload", 0, 2, 1, 0, 0);
        ld = 1'b0; md = 2'b00; stp = 8'd0;
        tick("step0_as_1", 0, 3, 1, 0, 0);

        stp = 8'd1; mn = 8'd3; mx = 8'd3;
        tick("max_eq_min", 0, 3, 1, 0, 0);
        mn = 8'd5; mx = 8'd4;
        tick("max_lt_min", 0, 3, 1, 0, 0);
        ld = 1'b1; ldv = 8'd200; mn = 8'd3; mx = 8'd20;
        tick("load_200", 0, 200, 1, 0, 0);
        ld = 1'b0;
        tick("resync_min", 0, 3, 1, 0, 0);
        tick("resync_next", 0, 4, 1, 0, 0);
        en = 1'b0;
        tick("en_low_hold", 0, 4, 1, 0, 0);

        e2 = 1'b1;
        tick("b2_1", 1, 1, 1, 0, 0);
        tick("b2_2", 1, 0, 0, 0, 1);
        tick("b2_3", 1, 1, 1, 0, 2);
        tick("b2_4", 1, 0, 0, 0, 3);
        tick("b2_sat", 1, 1, 1, 0, 3);
        tick("b2_sat2", 1, 0, 0, 0, 3);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations never checked, want 0", q.size());
            n_chk += q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
